// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus ACK/NACK levels.
package i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle     = 4'd0;
  localparam state_t StAddr     = 4'd1;
  localparam state_t StAddrAck  = 4'd2;
  localparam state_t StPtr      = 4'd3;
  localparam state_t StPtrAck   = 4'd4;
  localparam state_t StWdata    = 4'd5;
  localparam state_t StWdataAck = 4'd6;
  localparam state_t StRdata    = 4'd7;
  localparam state_t StRdataAck = 4'd8;
  localparam state_t StWaitStop = 4'd9;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// Register-side bus of the I2C target.
//   reg_addr  : register index (mirrors the internal pointer)
//   reg_wdata : write data, valid while reg_we
//   reg_we    : one-cycle write strobe
//   reg_rd    : one-cycle read strobe; reg_rdata sampled on the edge after the strobe cycle
//   reg_rdata : read data from the register space
//   busy      : target is addressed
interface i2c_slave_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    output reg_addr, reg_wdata, reg_we, reg_rd, busy,
    input  reg_rdata
  );

  modport master (
    input  reg_addr, reg_wdata, reg_we, reg_rd, busy,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Input conditioning for one open-drain I2C line: 2-FF synchronizer followed by a run filter.
// The filtered level only changes after FilterLen consecutive synchronized samples disagree
// with it. Rise/fall pulses are registered so they coincide with the new level.
//   clk_i, rst_ni : clock, async active-low reset (level resets to the idle-high bus state)
//   line_i        : raw bus line
//   level_o       : filtered level
//   rise_o/fall_o : one-cycle pulses on filtered level change
module i2c_line_filter #(
  parameter int unsigned FilterLen = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [2:0] run_q, run_d;
  logic       rise_q, fall_q;

  always_comb begin
    level_d = level_q;
    run_d   = 3'd0;
    if (sync2_q != level_q) begin
      if (run_q == 3'(FilterLen - 1)) begin
        level_d = sync2_q;
      end else begin
        run_d = run_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      run_q   <= 3'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      run_q   <= run_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing an 8-bit register space through a pointer protocol:
// [addr+W][ptr][data...] writes a burst, [addr+R] (optionally after Sr) reads from the pointer.
// SCL/SDA are oversampled on clk_i; no clock stretching; 7-bit addressing.
//   clk_i   : system clock (>= 20x SCL)
//   rst_ni  : async active-low reset
//   scl_i   : bus clock
//   sda_io  : bus data, driven low or released
//   reg_if  : register-side bus (address/data/strobes/busy)
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DevAddr   = 7'h50,
  parameter int unsigned FilterLen = 3,
  parameter int unsigned SdaHold   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  inout  wire        sda_io,
  i2c_slave_if.slave reg_if
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FilterLen(FilterLen)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (scl_i),
    .level_o(scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FilterLen(FilterLen)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (sda_io),
    .level_o(sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] reg_addr_q;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       rd_q, rd_d;
  logic       load_q, load_d;
  logic       busy_q, busy_d;
  logic       drive_q, drive_d;
  logic [7:0] hold_q, hold_d;

  logic       start, stop;
  logic [7:0] byte_in;
  logic       drive_tgt;

  // Our own drive only changes while scl_f is low, so it can never look like START/STOP.
  assign start   = sda_fall & scl_f;
  assign stop    = sda_rise & scl_f;
  assign byte_in = {shreg_q[6:0], sda_f};

  // Level to put on SDA once the hold timer expires after an SCL fall.
  always_comb begin
    case (state_q)
      StAddrAck, StPtrAck, StWdataAck: drive_tgt = 1'b1;
      StRdata:                         drive_tgt = ~shreg_q[7];
      default:                         drive_tgt = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    rd_d      = 1'b0;
    load_d    = rd_q;
    busy_d    = busy_q;
    drive_d   = drive_q;
    hold_d    = hold_q;

    // Pointer advances the cycle after a write strobe, or together with the read-data load.
    if (we_q) begin
      ptr_d = ptr_q + 8'd1;
    end
    if (load_q) begin
      shreg_d = reg_if.reg_rdata;
      ptr_d   = ptr_q + 8'd1;
    end

    if (scl_fall) begin
      hold_d = 8'(SdaHold);
    end else if (hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
      if (hold_q == 8'd1) begin
        drive_d = drive_tgt;
      end
    end

    if (start || stop) begin
      state_d   = start ? StAddr : StIdle;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      drive_d   = 1'b0;
      hold_d    = 8'd0;
    end else if (scl_rise) begin
      case (state_q)
        StAddr: begin
          shreg_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (byte_in[7:1] == DevAddr) begin
              state_d = StAddrAck;
              busy_d  = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          bit_cnt_d = 4'd0;
          if (shreg_q[0]) begin
            rd_d    = 1'b1;
            state_d = StRdata;
          end else begin
            state_d = StPtr;
          end
        end
        StPtr, StWdata: begin
          shreg_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (state_q == StPtr) begin
              ptr_d   = byte_in;
              state_d = StPtrAck;
            end else begin
              wdata_d = byte_in;
              we_d    = 1'b1;
              state_d = StWdataAck;
            end
          end
        end
        StPtrAck, StWdataAck: state_d = StWdata;
        StRdata: bit_cnt_d = bit_cnt_q + 4'd1;
        StRdataAck: begin
          if (sda_f == I2C_NACK) begin
            state_d = StWaitStop;
          end else begin
            rd_d      = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = StRdata;
          end
        end
        default: ;
      endcase
    end else if (scl_fall && state_q == StRdata) begin
      // The fall that ends the ACK slot (bit_cnt 0) must not shift: the MSB is still pending.
      if (bit_cnt_q == 4'd8) begin
        state_d   = StRdataAck;
        bit_cnt_d = 4'd0;
      end else if (bit_cnt_q != 4'd0) begin
        shreg_d = {shreg_q[6:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'd0;
      ptr_q      <= 8'd0;
      reg_addr_q <= 8'd0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
      hold_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      reg_addr_q <= ptr_q;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      drive_q    <= drive_d;
      hold_q     <= hold_d;
    end
  end

  assign sda_io = drive_q ? 1'b0 : 1'bz;

  assign reg_if.reg_addr  = reg_addr_q;
  assign reg_if.reg_wdata = wdata_q;
  assign reg_if.reg_we    = we_q;
  assign reg_if.reg_rd    = rd_q;
  assign reg_if.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 310;  // quarter SCL period in clock-relative time units (clk period 20)

  logic clk = 1'b0;
  logic rst_n;
  logic scl;
  logic m_low;
  wire  sda_bus;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_if reg_if ();

  i2c_slave u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .scl_i (scl),
    .sda_io(sda_bus),
    .reg_if(reg_if)
  );

  always #10 clk = ~clk;

  // Register space attached to the target: 256x8 RAM with one-cycle read.
  logic [7:0] ram [256];
  logic [7:0] rdata_q;
  assign reg_if.reg_rdata = rdata_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i * 3 + 1);
      rdata_q = 8'd0;
    end else begin
      if (reg_if.reg_we) ram[reg_if.reg_addr] = reg_if.reg_wdata;
      if (reg_if.reg_rd) rdata_q = ram[reg_if.reg_addr];
    end
  end

  // Transaction-level model: expected register-bus events in order.
  logic [7:0]  mdl_mem [256];
  logic [7:0]  mdl_ptr;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  int n_cmp = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  logic [15:0] last_wr = 16'd0;
  logic we_prev = 1'b0;
  logic rd_prev = 1'b0;
  logic quiet = 1'b0;
  logic sda_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_wr(input logic [7:0] d);
    exp_wr.push_back({mdl_ptr, d});
    mdl_mem[mdl_ptr] = d;
    mdl_ptr = mdl_ptr + 8'd1;
  endtask

  task automatic mdl_rd(output logic [7:0] d);
    exp_rd.push_back(mdl_ptr);
    d = mdl_mem[mdl_ptr];
    mdl_ptr = mdl_ptr + 8'd1;
  endtask

  // Compare process: every strobe the DUT issues is checked against the model's queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_if.reg_we) begin
        we_cnt++;
        check("we pulse width", 32'(we_prev), 32'd0);
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected write: got %0h/%0h expected none",
                   reg_if.reg_addr, reg_if.reg_wdata);
        end else begin
          check("write addr/data", 32'({reg_if.reg_addr, reg_if.reg_wdata}),
                32'(exp_wr.pop_front()));
        end
        last_wr = {reg_if.reg_addr, reg_if.reg_wdata};
      end
      if (reg_if.reg_rd) begin
        rd_cnt++;
        check("rd pulse width", 32'(rd_prev), 32'd0);
        if (exp_rd.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected read: got %0h expected none", reg_if.reg_addr);
        end else begin
          check("read addr", 32'(reg_if.reg_addr), 32'(exp_rd.pop_front()));
        end
      end
    end
    we_prev = reg_if.reg_we;
    rd_prev = reg_if.reg_rd;
    if (quiet && sda_bus === 1'b0 && !m_low) sda_low_seen = 1'b1;
  end

  // Bus master primitives; between bits SCL rests low.
  task automatic i2c_start;
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2 * Q);
    scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    b = sda_bus;  #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  initial begin
    logic       ack, b1, b2;
    logic [7:0] d1, d2, e1, e2;
    logic [7:0] bad_addr [2];

    rst_n = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    mdl_ptr = 8'd0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(i * 3 + 1);
    repeat (5) @(posedge clk);
    #1;
    check("reset sda released", 32'(sda_bus), 32'd1);
    check("reset reg_addr", 32'(reg_if.reg_addr), 32'd0);
    check("reset reg_wdata", 32'(reg_if.reg_wdata), 32'd0);
    check("reset reg_we", 32'(reg_if.reg_we), 32'd0);
    check("reset reg_rd", 32'(reg_if.reg_rd), 32'd0);
    check("reset busy", 32'(reg_if.busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Burst write: ptr 10h, A5h, 3Ch.
    i2c_start;
    send_byte(8'hA0, ack);
    check("t1 addr ack", 32'(ack), 32'(I2C_ACK));
    check("t1 busy addressed", 32'(reg_if.busy), 32'd1);
    mdl_ptr = 8'h10;
    send_byte(8'h10, ack);
    check("t1 ptr ack", 32'(ack), 32'(I2C_ACK));
    mdl_wr(8'hA5);
    send_byte(8'hA5, ack);
    check("t1 data0 ack", 32'(ack), 32'(I2C_ACK));
    mdl_wr(8'h3C);
    send_byte(8'h3C, ack);
    check("t1 data1 ack", 32'(ack), 32'(I2C_ACK));
    i2c_stop;
    repeat (20) @(posedge clk);
    check("t1 busy after stop", 32'(reg_if.busy), 32'd0);
    check("t1 reg_addr", 32'(reg_if.reg_addr), 32'h12);
    check("t1 write count", 32'(we_cnt), 32'd2);
    check("t1 last write", 32'(last_wr), 32'h113C);

    // Pointer write, repeated start, 2-byte read (ACK then NACK).
    i2c_start;
    send_byte(8'hA0, ack);
    mdl_ptr = 8'h20;
    send_byte(8'h20, ack);
    check("t2 ptr ack", 32'(ack), 32'(I2C_ACK));
    i2c_start;
    mdl_rd(e1);
    send_byte(8'hA1, ack);
    check("t2 read addr ack", 32'(ack), 32'(I2C_ACK));
    mdl_rd(e2);
    recv_byte(d1, I2C_ACK);
    recv_byte(d2, I2C_NACK);
    i2c_stop;
    repeat (20) @(posedge clk);
    check("t2 byte0 model", 32'(d1), 32'(e1));
    check("t2 byte1 model", 32'(d2), 32'(e2));
    check("t2 byte0 literal", 32'(d1), 32'h61);
    check("t2 byte1 literal", 32'(d2), 32'h64);
    check("t2 reg_addr", 32'(reg_if.reg_addr), 32'h22);
    check("t2 read count", 32'(rd_cnt), 32'd2);

    // Foreign addresses: NACKed, SDA never pulled by the target.
    bad_addr[0] = 8'hA2;
    bad_addr[1] = 8'hA4;
    quiet = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i2c_start;
      send_byte(bad_addr[i], ack);
      check("t3 foreign addr nack", 32'(ack), 32'(I2C_NACK));
      check("t3 busy low", 32'(reg_if.busy), 32'd0);
      i2c_stop;
      repeat (20) @(posedge clk);
    end
    quiet = 1'b0;
    check("t3 sda never low", 32'(sda_low_seen), 32'd0);
    check("t3 no writes", 32'(we_cnt), 32'd2);
    check("t3 no reads", 32'(rd_cnt), 32'd2);

    // Pointer wrap FFh -> 00h.
    i2c_start;
    send_byte(8'hA0, ack);
    mdl_ptr = 8'hFF;
    send_byte(8'hFF, ack);
    mdl_wr(8'h11);
    send_byte(8'h11, ack);
    mdl_wr(8'h22);
    send_byte(8'h22, ack);
    check("t4 data ack", 32'(ack), 32'(I2C_ACK));
    i2c_stop;
    repeat (20) @(posedge clk);
    check("t4 wrap last write", 32'(last_wr), 32'h0022);
    check("t4 reg_addr", 32'(reg_if.reg_addr), 32'h01);

    // START after 4 data bits drops the partial byte.
    i2c_start;
    send_byte(8'hA0, ack);
    mdl_ptr = 8'h30;
    send_byte(8'h30, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_start;
    send_byte(8'hA0, ack);
    check("t5 addr ack after sr", 32'(ack), 32'(I2C_ACK));
    mdl_ptr = 8'h05;
    send_byte(8'h05, ack);
    mdl_wr(8'h77);
    send_byte(8'h77, ack);
    i2c_stop;
    repeat (20) @(posedge clk);
    check("t5 write count", 32'(we_cnt), 32'd5);
    check("t5 last write", 32'(last_wr), 32'h0577);
    check("t5 reg_addr", 32'(reg_if.reg_addr), 32'h06);

    // Reset while the target drives a 0 data bit (RAM[40h] = C1h: bits 1,1,0,...).
    i2c_start;
    send_byte(8'hA0, ack);
    mdl_ptr = 8'h40;
    send_byte(8'h40, ack);
    i2c_start;
    mdl_rd(e1);
    send_byte(8'hA1, ack);
    recv_bit(b1);
    recv_bit(b2);
    check("t6 bit7", 32'(b1), 32'(e1[7]));
    check("t6 bit6", 32'(b2), 32'(e1[6]));
    check("t6 target drives 0", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6 sda released on reset", 32'(sda_bus), 32'd1);
    check("t6 busy on reset", 32'(reg_if.busy), 32'd0);
    check("t6 reg_addr on reset", 32'(reg_if.reg_addr), 32'd0);
    mdl_ptr = 8'd0;
    scl = 1'b1;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("pending writes", 32'(exp_wr.size()), 32'd0);
    check("pending reads", 32'(exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
